// File: rtl/fpu_pkg.sv
// Shared FPU definitions: controller state encoding and FP32 field widths.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fp_mul_pipe_ctrl_if.sv
// Input/output valid-ready handshake bundle for the FP multiplier controller.
interface fp_mul_pipe_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  import fpu_pkg::*;

  logic             in_valid;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready;

  // Producer/consumer side.
  modport master (
    output in_valid, in_tag, out_ready,
    input  in_ready, out_valid, out_tag
  );

  // Controller side.
  modport slave (
    input  in_valid, in_tag, out_ready,
    output in_ready, out_valid, out_tag
  );
endinterface

// File: rtl/fp_mul_pipe_stage_vld.sv
// One pipeline stage of valid/tag bookkeeping: occupancy, tag, advance and load enable.
module fp_mul_pipe_stage_vld
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld_i,
  input  logic [TAG_W-1:0] up_tag_i,
  input  logic             dn_adv_i,
  output logic             adv_o,
  output logic             en_o,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             vld_q, vld_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // An empty stage can always move; a full one only if downstream moves.
  // For the last stage dn_adv_i is out_ready, which gives vld ? out_ready : 1.
  assign adv_o = !vld_q || dn_adv_i;
  assign en_o  = up_vld_i && adv_o;
  assign vld_o = vld_q;
  assign tag_o = tag_q;

  // Next occupancy/tag: load from upstream, empty out when passing on, else hold.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (en_o) begin
      vld_d = 1'b1;
      tag_d = up_tag_i;
    end else if (adv_o) begin
      vld_d = 1'b0;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/fp_mul_pipe_ctrl.sv
// Sequencing controller for the FP32 multiplier pipeline: valid/tag tracking,
// per-stage load enables, back-pressure with bubble collapsing and drain flush.
// Optional performance counters are built when FP_MUL_PERF_CNT_EN is defined.
module fp_mul_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  fp_mul_pipe_ctrl_if.slave  bus,
  input  logic               flush,
  output logic [STAGES-1:0]  stg_en,
  output logic [STAGES-1:0]  stg_vld,
  output logic               busy
`ifdef FP_MUL_PERF_CNT_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        ops_done,
  output logic [31:0]        stall_cyc
`endif
);

  state_e state_q, state_d;
  logic   adv0;
  logic   accept;
  logic   pipe_empty;

  assign bus.in_ready = adv0 && (state_q == IDLE || state_q == RUN) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pipe_empty   = (stg_vld == '0);
  assign busy         = !pipe_empty || (state_q != IDLE);

  // Advance is a ripple from the output back to stage 0; each stage reads its
  // neighbour through the generate hierarchy.
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic             adv, en, vld, up_vld, dn_adv;
    logic [TAG_W-1:0] tag, up_tag;

    if (i == 0) begin : g_first
      assign up_vld = accept;
      assign up_tag = bus.in_tag;
      assign adv0   = adv;
    end else begin : g_mid
      assign up_vld = g_stg[i-1].vld;
      assign up_tag = g_stg[i-1].tag;
    end

    if (i == STAGES - 1) begin : g_last
      assign dn_adv        = bus.out_ready;
      assign bus.out_valid = vld;
      assign bus.out_tag   = tag;
    end else begin : g_inner
      assign dn_adv = g_stg[i+1].adv;
    end

    fp_mul_pipe_stage_vld #(.TAG_W(TAG_W)) u_stage (
      .clk      (CLK),
      .rst_n    (RST),
      .up_vld_i (up_vld),
      .up_tag_i (up_tag),
      .dn_adv_i (dn_adv),
      .adv_o    (adv),
      .en_o     (en),
      .vld_o    (vld),
      .tag_o    (tag)
    );

    assign stg_en[i]  = en;
    assign stg_vld[i] = vld;
  end

  // FSM next state: flush wins; drain completes once empty and flush released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush) state_d = DRAIN;
               else if (accept) state_d = RUN;
      RUN:     if (flush) state_d = DRAIN;
               else if (pipe_empty && !accept) state_d = IDLE;
      DRAIN:   if (pipe_empty && !flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

`ifdef FP_MUL_PERF_CNT_EN
  logic [31:0] ops_q, stall_q;

  assign ops_done  = ops_q;
  assign stall_cyc = stall_q;

  // Handshake and stall counters; clear beats a same-cycle increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else if (perf_clr) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready)  ops_q   <= ops_q + 32'd1;
      if (bus.out_valid && !bus.out_ready) stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe_ctrl.sv
// Self-checking bench for fp_mul_pipe_ctrl with a tag scoreboard.
// Exercises the FP_MUL_PERF_CNT_EN counters when that macro is defined.
module tb_fp_mul_pipe_ctrl;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              flush;
  logic [STAGES-1:0] stg_en;
  logic [STAGES-1:0] stg_vld;
  logic              busy;
`ifdef FP_MUL_PERF_CNT_EN
  logic              perf_clr;
  logic [31:0]       ops_done;
  logic [31:0]       stall_cyc;
`endif

  fp_mul_pipe_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fp_mul_pipe_ctrl #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .flush     (flush),
    .stg_en    (stg_en),
    .stg_vld   (stg_vld),
    .busy      (busy)
`ifdef FP_MUL_PERF_CNT_EN
    ,
    .perf_clr  (perf_clr),
    .ops_done  (ops_done),
    .stall_cyc (stall_cyc)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  logic [TAG_W-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic tick(input logic v, input logic [TAG_W-1:0] t, input logic ordy, input logic fl);
    @(posedge CLK);
    #1;
    bus.in_valid  = v;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((stg_vld != '0 || sb.size() != 0) && n < 30) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk(name, 32'(stg_vld), 32'd0);
    chk({name, "_sb"}, sb.size(), 32'd0);
  endtask

  // Scoreboard and output-stability monitor.
  logic             stall_prev;
  logic [TAG_W-1:0] tag_prev;
  always @(negedge CLK) begin
    if (!RST) begin
      stall_prev = 1'b0;
      tag_prev   = '0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid, 32'd1);
        chk("hold_tag", bus.out_tag, tag_prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 32'd1);
        else                chk("sb_tag", bus.out_tag, sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_tag);
      stall_prev = bus.out_valid && !bus.out_ready;
      tag_prev   = bus.out_tag;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_tag    = 4'h3;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
`ifdef FP_MUL_PERF_CNT_EN
    perf_clr      = 1'b0;
`endif

    // Reset held with a request pending.
    repeat (3) begin
      @(negedge CLK);
      chk("rst_vld", 32'(stg_vld), 32'd0);
      chk("rst_out_valid", bus.out_valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst_in_ready", bus.in_ready, 32'd1);
    chk("rst_busy_after", busy, 32'd0);

    // Streaming tags 0..9.
    for (int n = 0; n < 16; n++) begin
      tick(n < 10, TAG_W'(n), 1'b1, 1'b0);
      if (n >= 1 && n <= 3) chk("stream_latency", bus.out_valid, 32'd0);
      if (n == 4)           chk("stream_first_tag", bus.out_tag, 32'd0);
      if (n >= 4 && n <= 13) chk("stream_b2b", bus.out_valid, 32'd1);
      if (n == 14)          chk("stream_end", bus.out_valid, 32'd0);
      if (n < 10)           chk("stream_ready", bus.in_ready, 32'd1);
    end
    drain("stream_drain");

    // Back-pressure: fill with tags 1..4, stall, then release.
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, TAG_W'(n + 1), 1'b0, 1'b0);
      chk("bp_fill_ready", bus.in_ready, 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("bp_full", 32'(stg_vld), 32'hF);
      chk("bp_tag", bus.out_tag, 32'd1);
      chk("bp_in_ready", bus.in_ready, 32'd0);
      chk("bp_en", 32'(stg_en), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("bp_drain_valid", bus.out_valid, 32'd1);
      chk("bp_drain_tag", bus.out_tag, 32'(k + 1));
    end
    drain("bp_empty");

    // Bubble collapse: tag 5, two idle cycles, tag 6, output blocked.
    tick(1'b1, 4'h5, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 4'h6, 1'b0, 1'b0);
    chk("bub_en_accept", 32'(stg_en), 32'h9);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("bub_en_move", 32'(stg_en), 32'h2);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("bub_vld", 32'(stg_vld), 32'hC);
    chk("bub_tag", bus.out_tag, 32'd5);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("bub_vld_hold", 32'(stg_vld), 32'hC);
    chk("bub_en_idle", 32'(stg_en), 32'd0);
    drain("bub_drain");

    // Flush pulse with 3 ops in flight; requester keeps asking.
    tick(1'b1, 4'h7, 1'b1, 1'b0);
    tick(1'b1, 4'h8, 1'b1, 1'b0);
    tick(1'b1, 4'h9, 1'b1, 1'b0);
    for (int n = 3; n <= 8; n++) begin
      tick(1'b1, 4'hA, 1'b1, n == 3);
      chk("flush_in_ready", bus.in_ready, 32'(n == 8));
      chk("flush_busy", busy, 32'(n != 8));
    end
    drain("flush_drain");

`ifdef FP_MUL_PERF_CNT_EN
    // Counters: clear, 7 handshakes with 2 stall cycles, clear again.
    @(posedge CLK);
    #1 perf_clr = 1'b1;
    @(posedge CLK);
    #1 perf_clr = 1'b0;
    @(negedge CLK);
    #1;
    chk("perf_clr_ops", ops_done, 32'd0);
    chk("perf_clr_stall", stall_cyc, 32'd0);
    for (int n = 0; n < 4; n++) tick(1'b1, TAG_W'(n), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) tick(1'b1, TAG_W'(n + 8), 1'b1, 1'b0);
    drain("perf_drain");
    chk("perf_ops", ops_done, 32'd7);
    chk("perf_stall", stall_cyc, 32'd2);
    @(posedge CLK);
    #1 perf_clr = 1'b1;
    @(negedge CLK);
    chk("perf_pre_clr", ops_done, 32'd7);
    @(posedge CLK);
    #1 perf_clr = 1'b0;
    @(negedge CLK);
    chk("perf_post_clr_ops", ops_done, 32'd0);
    chk("perf_post_clr_stall", stall_cyc, 32'd0);
`endif

    chk("sb_empty_end", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
